// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded bursts.
// Optional write-acknowledge checker enabled by defining FIFO_WR_ARB_ACK_CHECK_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          wr_ack,
  output logic                          ack_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  localparam logic [OW-1:0] OWNER_LAST = OW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 accept;
  logic                 found;
  logic [OW-1:0]        winner;
  int                   idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    accept  = (state_q == BURST) && req[owner_q] && !full;
    wr_en   = accept;
    req_ack = '0;
    data_in = '0;
    if (state_q == BURST) begin
      data_in          = req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];
      req_ack[owner_q] = accept;
    end
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = BURST;
          owner_d = winner;
          gnt_d   = NUM_REQ'(1) << winner;
          beat_d  = '0;
        end
      end
      BURST: begin
        // Owner withdrawing its request ends the grant just like a completed burst.
        if (!req[owner_q] || (accept && (req_last[owner_q] || beat_q == BEAT_LAST))) begin
          state_d = IDLE;
          gnt_d   = '0;
          beat_d  = '0;
          ptr_d   = (owner_q == OWNER_LAST) ? '0 : owner_q + 1'b1;
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt = gnt_q;

`ifdef FIFO_WR_ARB_ACK_CHECK_EN
  logic wr_en_dly_q, wr_en_dly_d;
  logic ack_err_q, ack_err_d;

  // The FIFO acknowledges one cycle after each write; any disagreement latches an error.
  always_comb begin
    wr_en_dly_d = wr_en;
    ack_err_d   = ack_err_q | (wr_en_dly_q != wr_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_dly_q <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      wr_en_dly_q <= wr_en_dly_d;
      ack_err_q   <= ack_err_d;
    end
  end

  assign ack_err = ack_err_q;
`else
  logic unused_wr_ack;
  assign unused_wr_ack = wr_ack;
  assign ack_err       = 1'b0;
`endif

endmodule
